conv_seq_ctrl: RTL and testbench
================================

// Module: conv_seq_ctrl
// PURPOSE
//  Control FSM for the 1-D convolution layer datapath (N-input, M-tap, T-bit, P=1).
//  Sequences input-memory writes, x/f memory reads and MAC accumulate/clear pulses.
//  Raises the output-valid handshake for each of the N-M+1 results.
//  Sits between the s_*_x / m_*_y stream handshakes and the x RAM, f ROM and MAC of conv_N_M_T_1.
// PARAMETERS
//  N     32  input vector length (x values per frame)
//  M     8   filter taps; N-M+1 outputs per frame
//  PIPE  1   cycles from read-address issue to operand valid at MAC (RAM/ROM read latency)
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            synchronous, ACTIVE-LOW (reset==0 resets on the clock edge)
//  s_valid_x  in   1            input sample valid
//  s_ready_x  out  1            block accepts input sample
//  wr_en_x    out  1            write enable to x RAM (= s_valid_x && s_ready_x)
//  wr_addr_x  out  $clog2(N)    x RAM write address
//  rd_addr_x  out  $clog2(N)    x RAM read address
//  rd_addr_f  out  $clog2(M)    f ROM read address
//  clear_acc  out  1            MAC loads product instead of adding (first tap)
//  en_acc     out  1            MAC accumulate enable
//  m_valid_y  out  1            accumulator holds a finished output
//  m_ready_y  in   1            downstream accepts output
// BEHAVIOUR
//  After reset: state=LOAD; wr_addr_x=0, k=0, j=0; en_acc=clear_acc=m_valid_y=0; s_ready_x=1.
//  Reset mid-operation: all counters zeroed; any pending output is dropped; LOAD re-entered.
//  s_ready_x = (state==LOAD). wr_en_x and s_ready_x are combinational; all other outputs are registered.
//  LOAD:
//   - Each s_valid_x && s_ready_x writes x RAM at wr_addr_x, then wr_addr_x++.
//   - The accept at wr_addr_x==N-1 wraps wr_addr_x to 0 and moves to ISSUE.
//   - s_ready_x is low from the following cycle.
//  ISSUE (output index k, tap j):
//   - One read per cycle: rd_addr_x=k+j, rd_addr_f=j, j=0..M-1. Never stalls.
//   - After j=M-1: j resets to 0 and the state moves to DRAIN.
//  en_acc is the issue strobe delayed by PIPE cycles.
//   - clear_acc is asserted together with en_acc for the j=0 issue only.
//   - Exactly M en_acc pulses occur per output, on consecutive cycles.
//  DRAIN: waits PIPE cycles after the last issue (the last en_acc has fired), then moves to OUT.
//  OUT:
//   - m_valid_y=1 and is held, with no read issue and no en_acc, until m_valid_y && m_ready_y.
//   - On that handshake: if k<N-M, k++ and go to ISSUE on the next cycle; else k=0 and go to LOAD.
//   - m_valid_y drops on the cycle after the handshake.
//  m_ready_y while m_valid_y=0 has no effect.
//  s_valid_x outside LOAD is ignored (not accepted).
//  Address arithmetic: k+j <= N-1 always; no wrap on rd_addr_x.
//  Minimum latency per output: M+PIPE+1 cycles, output cycle included (M=8, PIPE=1 -> 10 cycles).
//  Next frame loading does not overlap computation of the current frame.
// TESTING
//  1 reset=0 for 2 edges mid-ISSUE (k=10) -> next cycle s_ready_x=1, m_valid_y=0, en_acc=0, k=0.
//  2 s_valid_x held high 32 cycles -> wr_addr_x 0..31 with wr_en_x each cycle; s_ready_x=0 on the cycle after the 32nd accept.
//  3 first output -> rd_addr_x/rd_addr_f 0..7/0..7 on 8 consecutive cycles.
//      en_acc for 8 cycles, 1 cycle later; clear_acc only with the first en_acc.
//      m_valid_y=1 2 cycles after the last issue.
//  4 m_ready_y low 5 cycles while m_valid_y=1 -> m_valid_y held, no en_acc, no address change.
//      k=3 output then issues rd_addr_x 3..10.
//  5 one frame, ready always high -> exactly 25 m_valid_y handshakes.
//      Last output uses rd_addr_x 24..31; then LOAD and s_ready_x=1.
//  6 instantiated in conv_32_8_16_1 under the randomised valid/ready system bench (312 frames):
//      9984 inputs in -> 7800 outputs match the expected file, 0 errors.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencing FSM for the 1-D convolution datapath: loads the x RAM, issues x/f reads per output,
// drives the MAC accumulate/clear strobes and presents the output-valid handshake.
module conv_seq_ctrl #(
    parameter int unsigned N    = 32,
    parameter int unsigned M    = 8,
    parameter int unsigned PIPE = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 s_valid_x,
    output logic                                 s_ready_x,
    output logic                                 wr_en_x,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_addr_x,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] rd_addr_x,
    output logic [((M > 1) ? $clog2(M) : 1)-1:0] rd_addr_f,
    output logic                                 clear_acc,
    output logic                                 en_acc,
    output logic                                 m_valid_y,
    input  logic                                 m_ready_y
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned FW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned DW = (PIPE > 1) ? $clog2(PIPE) : 1;

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [AW-1:0]   k;
    logic [AW-1:0]   next_k;
    logic [FW-1:0]   j;
    logic [FW-1:0]   next_j;
    logic [DW-1:0]   dcnt;
    logic [DW-1:0]   next_dcnt;
    logic [AW-1:0]   next_wr_addr;
    logic [PIPE-1:0] en_pipe;
    logic [PIPE-1:0] clr_pipe;
    logic            issue;
    logic            handshake;

    assign s_ready_x = (state == LOAD);
    assign wr_en_x   = s_valid_x && s_ready_x;
    assign issue     = (state == ISSUE);
    assign handshake = m_valid_y && m_ready_y;
    assign en_acc    = en_pipe[PIPE-1];
    assign clear_acc = clr_pipe[PIPE-1];

    // Next-state and counter update
    always_comb begin
        next_state   = state;
        next_k       = k;
        next_j       = j;
        next_dcnt    = dcnt;
        next_wr_addr = wr_addr_x;
        case (state)
            LOAD: begin
                if (wr_en_x) begin
                    if (wr_addr_x == AW'(N - 1)) begin
                        next_wr_addr = '0;
                        next_state   = ISSUE;
                    end else begin
                        next_wr_addr = wr_addr_x + AW'(1);
                    end
                end
            end
            ISSUE: begin
                if (j == FW'(M - 1)) begin
                    next_j     = '0;
                    next_dcnt  = '0;
                    next_state = DRAIN;
                end else begin
                    next_j = j + FW'(1);
                end
            end
            DRAIN: begin
                if (dcnt == DW'(PIPE - 1)) begin
                    next_state = OUT;
                end else begin
                    next_dcnt = dcnt + DW'(1);
                end
            end
            OUT: begin
                if (handshake) begin
                    if (k < AW'(N - M)) begin
                        next_k     = k + AW'(1);
                        next_state = ISSUE;
                    end else begin
                        next_k     = '0;
                        next_state = LOAD;
                    end
                end
            end
            default: next_state = LOAD;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= LOAD;
            k         <= '0;
            j         <= '0;
            dcnt      <= '0;
            wr_addr_x <= '0;
            rd_addr_x <= '0;
            rd_addr_f <= '0;
            m_valid_y <= 1'b0;
            en_pipe   <= '0;
            clr_pipe  <= '0;
        end else begin
            state     <= next_state;
            k         <= next_k;
            j         <= next_j;
            dcnt      <= next_dcnt;
            wr_addr_x <= next_wr_addr;
            m_valid_y <= (next_state == OUT);
            // Addresses hold the last issue through DRAIN/OUT
            if (next_state == ISSUE) begin
                rd_addr_x <= next_k + AW'(next_j);
                rd_addr_f <= next_j;
            end
            en_pipe[0]  <= issue;
            clr_pipe[0] <= issue && (j == '0);
            for (int i = 1; i < int'(PIPE); i++) begin
                en_pipe[i]  <= en_pipe[i-1];
                clr_pipe[i] <= clr_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: stimulus pushes expected writes, reads and outputs;
// a negedge monitor pops and compares as the DUT presents them.
module tb_conv_seq_ctrl;

    localparam int N    = 32;
    localparam int M    = 8;
    localparam int PIPE = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_valid_x;
    logic       s_ready_x;
    logic       wr_en_x;
    logic [4:0] wr_addr_x;
    logic [4:0] rd_addr_x;
    logic [2:0] rd_addr_f;
    logic       clear_acc;
    logic       en_acc;
    logic       m_valid_y;
    logic       m_ready_y;

    always #5 clk = ~clk;

    conv_seq_ctrl #(.N(N), .M(M), .PIPE(PIPE)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .wr_en_x   (wr_en_x),
        .wr_addr_x (wr_addr_x),
        .rd_addr_x (rd_addr_x),
        .rd_addr_f (rd_addr_f),
        .clear_acc (clear_acc),
        .en_acc    (en_acc),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int q_wr[$];
    int q_rx[$];
    int q_rf[$];
    int q_rc[$];
    int q_y[$];
    int wr_seen  = 0;
    int hs_count = 0;
    int cyc      = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected traffic for one frame: 32 writes, and reads/outputs for k = 0..last_k
    task automatic push_frame(input int last_k);
        for (int a = 0; a < N; a++) q_wr.push_back(a);
        for (int kk = 0; kk <= last_k; kk++) begin
            for (int jj = 0; jj < M; jj++) begin
                q_rx.push_back(kk + jj);
                q_rf.push_back(jj);
                q_rc.push_back((jj == 0) ? 1 : 0);
            end
            q_y.push_back(kk);
        end
    endtask

    task automatic wait_wr(input int n, input int budget);
        for (int i = 0; i < budget && wr_seen < n; i++) begin
            @(negedge clk); #1;
        end
        if (wr_seen < n) fail_now("wr_timeout");
    endtask

    task automatic wait_hs(input int n, input int budget);
        for (int i = 0; i < budget && hs_count < n; i++) begin
            @(negedge clk); #1;
        end
        if (hs_count < n) fail_now("hs_timeout");
    endtask

    // Monitor
    int e;
    int en_cnt      = 0;
    int first_x     = 0;
    int last_en_cyc = -100;
    int prev_x      = 0;
    int prev_f      = 0;
    bit prev_mv     = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (reset !== 1'b1) begin
            en_cnt      = 0;
            prev_mv     = 1'b0;
            last_en_cyc = -100;
        end else begin
            if (wr_en_x) begin
                if (q_wr.size() == 0) fail_now("wr_unexpected");
                else begin
                    e = q_wr.pop_front();
                    chk("wr_addr_x", int'(wr_addr_x), e);
                end
                wr_seen++;
            end
            if (en_acc) begin
                chk("en_acc_in_out", int'(m_valid_y), 0);
                if (en_cnt > 0) chk("en_acc_gap", cyc - last_en_cyc, 1);
                if (q_rx.size() == 0) fail_now("en_acc_unexpected");
                else begin
                    e = q_rx.pop_front();
                    chk("rd_addr_x", prev_x, e);
                    e = q_rf.pop_front();
                    chk("rd_addr_f", prev_f, e);
                    e = q_rc.pop_front();
                    chk("clear_acc", int'(clear_acc), e);
                end
                if (en_cnt == 0) first_x = prev_x;
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (m_valid_y && !prev_mv) chk("valid_latency", cyc - last_en_cyc, 1);
            if (m_valid_y && m_ready_y) begin
                if (q_y.size() == 0) fail_now("output_unexpected");
                else begin
                    e = q_y.pop_front();
                    chk("output_k", first_x, e);
                    chk("taps_per_output", en_cnt, M);
                end
                en_cnt = 0;
                hs_count++;
            end
            prev_mv = m_valid_y;
        end
        prev_x = int'(rd_addr_x);
        prev_f = int'(rd_addr_f);
    end

    initial begin
        reset     = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_s_ready_x", int'(s_ready_x), 1);
        chk("rst_m_valid_y", int'(m_valid_y), 0);
        chk("rst_en_acc", int'(en_acc), 0);
        chk("rst_clear_acc", int'(clear_acc), 0);
        chk("rst_wr_addr_x", int'(wr_addr_x), 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Frame A: continuous load, stall on the k=3 output
        push_frame(N - M);
        @(posedge clk); #1;
        s_valid_x = 1'b1;
        m_ready_y = 1'b1;
        wait_wr(32, 100);
        @(negedge clk); #1;
        chk("load_done_s_ready_x", int'(s_ready_x), 0);
        chk("load_done_wr_en_x", int'(wr_en_x), 0);
        repeat (20) @(posedge clk);
        #1;
        s_valid_x = 1'b0;
        wait_hs(3, 200);
        @(posedge clk); #1;
        m_ready_y = 1'b0;
        for (int i = 0; i < 50 && !m_valid_y; i++) begin
            @(negedge clk); #1;
        end
        chk("stall_valid_seen", int'(m_valid_y), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("stall_m_valid_y", int'(m_valid_y), 1);
            chk("stall_en_acc", int'(en_acc), 0);
            chk("stall_rd_addr_x", int'(rd_addr_x), 10);
            chk("stall_rd_addr_f", int'(rd_addr_f), 7);
        end
        @(posedge clk); #1;
        m_ready_y = 1'b1;
        wait_hs(25, 400);
        @(negedge clk); #1;
        chk("frame_a_end_s_ready_x", int'(s_ready_x), 1);
        chk("frame_a_end_m_valid_y", int'(m_valid_y), 0);
        chk("frame_a_reads_left", q_rx.size(), 0);

        // Frame B: reset for two edges while issuing k=10
        push_frame(10);
        @(posedge clk); #1;
        s_valid_x = 1'b1;
        wait_wr(64, 100);
        @(posedge clk); #1;
        s_valid_x = 1'b0;
        wait_hs(35, 300);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("midrst_s_ready_x", int'(s_ready_x), 1);
        chk("midrst_m_valid_y", int'(m_valid_y), 0);
        chk("midrst_en_acc", int'(en_acc), 0);
        chk("midrst_clear_acc", int'(clear_acc), 0);
        chk("midrst_wr_addr_x", int'(wr_addr_x), 0);
        q_rx.delete();
        q_rf.delete();
        q_rc.delete();
        q_y.delete();
        @(posedge clk); #1;
        reset = 1'b1;

        // Frame C: full frame after reset, ready always high
        push_frame(N - M);
        @(posedge clk); #1;
        s_valid_x = 1'b1;
        wait_wr(96, 100);
        @(posedge clk); #1;
        s_valid_x = 1'b0;
        wait_hs(60, 400);
        @(negedge clk); #1;
        chk("frame_c_end_s_ready_x", int'(s_ready_x), 1);
        chk("frame_c_reads_left", q_rx.size(), 0);
        chk("frame_c_outputs_left", q_y.size(), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
